serializador_tx_2b: RTL

//  Transmit-side parallel-to-serial stage; directly upstream of phy_rx across the 2-bit serial link.

---
 rtl/serializador_tx_2b.sv | 74 +++++++
 1 files changed

// File: rtl/serializador_tx_2b.sv
// serializador_tx_2b: buffered parallel-to-serial transmitter with COM alignment preamble
module serializador_tx_2b #(
  parameter int         ALIGN_COUNT = 4,
  parameter logic [7:0] COM_SYM     = 8'hBC
) (
  input  logic       clk16f,
  input  logic       reset_L,
  input  logic [8:0] data_in,
  output logic       in_ready,
  output logic [1:0] serial,
  output logic       sym_start,
  output logic       aligned
);
  localparam int CW = ALIGN_COUNT > 1 ? $clog2(ALIGN_COUNT) : 1;
  typedef enum logic {ALIGN, ACTIVE} state_t;
  state_t        state, state_next;
  logic [CW-1:0] align_cnt, align_cnt_next;
  logic [1:0]    phase;
  logic [5:0]    shadow;
  logic          buf_full;
  logic [7:0]    buf_byte;
  logic [7:0]    sym;
  logic          drain;
  logic          accept;
  assign in_ready = (state == ACTIVE) && !buf_full;
  assign aligned  = (state == ACTIVE);
  assign accept   = data_in[8] && in_ready;
  // alignment state and preamble counter
  always_ff @(posedge clk16f or negedge reset_L)
    if (!reset_L) begin
      state     <= ALIGN;
      align_cnt <= '0;
    end else begin
      state     <= state_next;
      align_cnt <= align_cnt_next;
    end
  // symbol choice at each phase-0 edge and preamble progress
  always_comb begin
    state_next     = state;
    align_cnt_next = align_cnt;
    sym            = COM_SYM;
    drain          = 1'b0;
    if (phase == 2'd0) begin
      if (state == ALIGN) begin
        align_cnt_next = align_cnt + 1'b1;
        state_next     = (align_cnt == CW'(ALIGN_COUNT - 1)) ? ACTIVE : ALIGN;
      end else if (buf_full) begin
        sym   = buf_byte;
        drain = 1'b1;
      end
    end
  end
  // shift register, phase counter and one-entry input buffer
  always_ff @(posedge clk16f or negedge reset_L)
    if (!reset_L) begin
      phase     <= 2'd0;
      serial    <= 2'b00;
      shadow    <= '0;
      sym_start <= 1'b0;
      buf_full  <= 1'b0;
      buf_byte  <= '0;
    end else begin
      phase     <= phase + 2'd1;
      serial    <= (phase == 2'd0) ? sym[7:6] : shadow[5:4];
      shadow    <= (phase == 2'd0) ? sym[5:0] : {shadow[3:0], 2'b00};
      sym_start <= (phase == 2'd0);
      if (accept) begin
        buf_full <= 1'b1;
        buf_byte <= data_in[7:0];
      end else if (drain) begin
        buf_full <= 1'b0;
      end
    end
endmodule
